// File: rtl/multiword_add_seq_if.sv
// Request/response bundle for multiword_add_seq.
//   master: drives start, a, b, cin (and sub when MWADD_SUB_EN is defined),
//           observes busy, done, sum, cout
//   slave : the sequencer side of the same signals
// Optional feature macro: MWADD_SUB_EN (adds the sub request bit).
interface multiword_add_seq_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = 8 * WORDS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef MWADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output start, a, b, cin,
`ifdef MWADD_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef MWADD_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: adds two WORDS*8-bit operands through one shared
// 8-bit hybrid carry-lookahead adder, one limb per clock, LSB limb first.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - multiword_add_seq_if.slave: start/a/b/cin[/sub] in, busy/done/sum/cout out
// Optional feature macro: MWADD_SUB_EN -> sub request computes a - b (cout = no borrow).
module multiword_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    multiword_add_seq_if.slave bus
);
    localparam int unsigned W     = 8 * WORDS;
    localparam int unsigned CNT_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef MWADD_SUB_EN
    logic             sub_q, sub_d;
`endif

    logic [7:0]       a_limb;
    logic [7:0]       b_limb;
    logic [7:0]       b_eff;
    logic [7:0]       limb_sum;
    logic             c8;

    // 4-bit carry-lookahead block: returns {c4, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Hybrid 8-bit adder: two lookahead nibbles, carry rippled between them
    function automatic logic [8:0] hybridadder8(input logic [7:0] x, input logic [7:0] y,
                                                input logic c0);
        logic [4:0] lo;
        logic [4:0] hi;
        lo = cla4(x[3:0], y[3:0], c0);
        hi = cla4(x[7:4], y[7:4], lo[4]);
        return {hi[4], hi[3:0], lo[3:0]};
    endfunction

    // Select the current limb of each latched operand
    always_comb begin
        a_limb = '0;
        b_limb = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_limb = a_q[8*i +: 8];
                b_limb = b_q[8*i +: 8];
            end
        end
    end

`ifdef MWADD_SUB_EN
    assign b_eff = sub_q ? ~b_limb : b_limb;
`else
    assign b_eff = b_limb;
`endif

    assign {c8, limb_sum} = hybridadder8(a_limb, b_eff, carry_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MWADD_SUB_EN
        sub_d   = sub_q;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ADD;
`ifdef MWADD_SUB_EN
                    sub_d   = bus.sub;
                    // Two's-complement subtract: the +1 enters as limb-0 carry
                    carry_d = bus.sub ? 1'b1 : bus.cin;
`else
                    carry_d = bus.cin;
`endif
                end
            end
            ADD: begin
                for (int i = 0; i < int'(WORDS); i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[8*i +: 8] = limb_sum;
                    end
                end
                carry_d = c8;
                if (cnt_q == CNT_W'(WORDS - 1)) begin
                    cout_d  = c8;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MWADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MWADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (WORDS=4 main instance, WORDS=2 side instance).
// Reference: plain wide-integer arithmetic on whole operands.
module tb_multiword_add_seq;
    logic clk;
    logic rst;

    int n_pass;
    int n_tot;

    multiword_add_seq_if #(.WORDS(4)) ifc ();
    multiword_add_seq_if #(.WORDS(2)) ifc2 ();

    multiword_add_seq #(.WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    multiword_add_seq #(.WORDS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (ifc2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Whole-operand reference: {cout, sum}
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic cin_i,
                         input logic sub_i, output logic [31:0] s, output logic co,
                         output int lat, output int busy_cyc);
        @(negedge clk);
        ifc.a     = a_i;
        ifc.b     = b_i;
        ifc.cin   = cin_i;
`ifdef MWADD_SUB_EN
        ifc.sub   = sub_i;
`else
        if (sub_i) $display("note: sub requested without MWADD_SUB_EN");
`endif
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        // Operands must be captured; disturb the inputs immediately
        ifc.a     = $urandom;
        ifc.b     = $urandom;
        ifc.cin   = 1'($urandom % 2);
        busy_cyc  = ifc.busy ? 1 : 0;
        lat       = 0;
        while (!ifc.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (ifc.busy) busy_cyc++;
        end
        if (!ifc.done) chk("done_timeout", 64'(ifc.done), 64'd1);
        s  = ifc.sum;
        co = ifc.cout;
        @(posedge clk);
        #1;
        chk("done_pulse_width", 64'(ifc.done), 64'd0);
    endtask

    initial begin
        logic [31:0] s;
        logic        co;
        int          lat;
        int          bc;
        logic [32:0] exp;
        int          pulses;
        int          gap;
        logic [31:0] s_at_done;

        n_pass = 0;
        n_tot  = 0;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[2] = '{32'h12345678, 32'h00000000, 1'b1, 32'h12345679, 1'b0};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[5] = '{32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0};

        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        ifc.cin   = 1'b0;
        ifc2.start = 1'b0;
        ifc2.a     = '0;
        ifc2.b     = '0;
        ifc2.cin   = 1'b0;
`ifdef MWADD_SUB_EN
        ifc.sub   = 1'b0;
        ifc2.sub  = 1'b0;
`endif
        #1;
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_done", 64'(ifc.done), 64'd0);
        chk("rst_sum",  64'(ifc.sum),  64'd0);
        chk("rst_cout", 64'(ifc.cout), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s, co, lat, bc);
            chk($sformatf("vec%0d_sum", i),  64'(s),  64'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].co));
            chk($sformatf("vec%0d_lat", i),  64'(lat), 64'd4);
            if (i == 0) chk("vec0_busy_cycles", 64'(bc), 64'd4);
        end

        // Randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom % 2);
`ifdef MWADD_SUB_EN
            rs = 1'($urandom % 2);
`else
            rs = 1'b0;
`endif
            if (i % 8 == 0) ra = 32'hFFFFFFFF;
            exp = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, s, co, lat, bc);
            chk($sformatf("rnd%0d_sum", i),  64'(s),  64'(exp[31:0]));
            chk($sformatf("rnd%0d_cout", i), 64'(co), 64'(exp[32]));
        end

        // start pulsed during ADD is ignored
        @(negedge clk);
        ifc.a = 32'h1; ifc.b = 32'h1; ifc.cin = 1'b0; ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        @(negedge clk);
        ifc.a = 32'hFFFFFFFF; ifc.b = 32'hFFFFFFFF; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        pulses    = 0;
        s_at_done = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (ifc.done) begin
                pulses++;
                s_at_done = ifc.sum;
            end
        end
        chk("ign_start_pulses", 64'(pulses), 64'd1);
        chk("ign_start_sum", 64'(s_at_done), 64'd2);
        chk("ign_start_idle", 64'(ifc.busy), 64'd0);

        // Reset in the second ADD cycle aborts immediately
        @(negedge clk);
        ifc.a = 32'h0000FF00; ifc.b = 32'h00000100; ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(ifc.busy), 64'd0);
        chk("abort_done", 64'(ifc.done), 64'd0);
        chk("abort_sum",  64'(ifc.sum),  64'd0);
        chk("abort_cout", 64'(ifc.cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h0000000A, 32'h00000005, 1'b0, 1'b0, s, co, lat, bc);
        chk("post_abort_sum", 64'(s), 64'h0F);
        chk("post_abort_lat", 64'(lat), 64'd4);

        // start held high: back-to-back ops spaced WORDS+2 cycles
        @(negedge clk);
        ifc.a = 32'h3; ifc.b = 32'h4; ifc.cin = 1'b0; ifc.start = 1'b1;
        lat = 0;
        while (!ifc.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held_first_done", 64'(ifc.done), 64'd1);
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (!ifc.done && gap < 20);
        ifc.start = 1'b0;
        chk("held_gap", 64'(gap), 64'd6);
        chk("held_sum", 64'(ifc.sum), 64'd7);
        repeat (3) @(posedge clk);

`ifdef MWADD_SUB_EN
        do_op(32'h5, 32'h7, 1'b0, 1'b1, s, co, lat, bc);
        chk("sub_neg_sum",  64'(s),  64'hFFFFFFFE);
        chk("sub_neg_cout", 64'(co), 64'd0);
        do_op(32'h7, 32'h5, 1'b1, 1'b1, s, co, lat, bc);
        chk("sub_pos_sum",  64'(s),  64'h2);
        chk("sub_pos_cout", 64'(co), 64'd1);
`endif

        // WORDS=2 instance
        @(negedge clk);
        ifc2.a = 16'h00FF; ifc2.b = 16'h0001; ifc2.cin = 1'b0; ifc2.start = 1'b1;
        @(posedge clk);
        #1;
        ifc2.start = 1'b0;
        lat = 0;
        while (!ifc2.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w2_lat",  64'(lat), 64'd2);
        chk("w2_sum",  64'(ifc2.sum), 64'h0100);
        chk("w2_cout", 64'(ifc2.cout), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
